// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and related arbiters.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SEND   = 2'd1,
    ARB_WAIT   = 2'd2,
    ARB_SETTLE = 2'd3
  } arb_state_e;

  localparam int         ARB_MAX_REQ  = 8;
  localparam logic [7:0] ARB_TAG_BASE = 8'hA0;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and serializer handshake bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   i_Req_DV;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   o_Req_Ack;
  logic [IW-1:0]        o_Grant_Idx;
  logic                 o_Busy;
  logic                 o_Tx_DV;
  logic [7:0]           o_Tx_Byte;
  logic                 i_Tx_Active;
  logic                 i_Tx_Done;

  modport master (
    input  i_Req_DV, i_Req_Byte, i_Tx_Active, i_Tx_Done,
    output o_Req_Ack, o_Grant_Idx, o_Busy, o_Tx_DV, o_Tx_Byte
  );

  modport slave (
    output i_Req_DV, i_Req_Byte, i_Tx_Active, i_Tx_Done,
    input  o_Req_Ack, o_Grant_Idx, o_Busy, o_Tx_DV, o_Tx_Byte
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin winner search: first set request after i_Last, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_Req,
  input  logic [IW-1:0] i_Last,
  output logic          o_Valid,
  output logic [IW-1:0] o_Idx
);

  // Scan farthest offset first so the nearest requester after i_Last wins.
  always_comb begin
    o_Valid = 1'b0;
    o_Idx   = '0;
    for (int off = N; off >= 1; off--) begin
      if (i_Req[(int'(i_Last) + off) % N]) begin
        o_Valid = 1'b1;
        o_Idx   = IW'((int'(i_Last) + off) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Optional `UART_ARB_TAG_EN: precede each data frame with tag byte TAG_BASE | grant index.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NUM_REQ  = 4,
  parameter logic [7:0] TAG_BASE = ARB_TAG_BASE
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  uart_tx_arbiter_if.master  bus
);

  localparam int            IW       = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be 2..8");
  end
  if (TAG_BASE[2:0] != 3'b000) begin : g_bad_tag_base
    $error("uart_tx_arbiter: TAG_BASE low 3 bits must be zero");
  end

  arb_state_e           r_State, w_Next;
  logic [IW-1:0]        r_Last, w_Last_Nxt;
  logic [IW-1:0]        r_Grant, w_Grant_Nxt;
  logic                 r_Tx_DV;
  logic [7:0]           r_Tx_Byte, w_Byte_Nxt;
  logic [NUM_REQ-1:0]   r_Ack, w_Ack_Nxt;
  logic                 r_Busy;
  logic                 w_Pick_Valid;
  logic [IW-1:0]        w_Pick_Idx;
  logic [7:0]           w_Pick_Byte;
`ifdef UART_ARB_TAG_EN
  logic                 r_Tag, w_Tag_Nxt;
  logic                 r_Pend, w_Pend_Nxt;
  logic [7:0]           r_Data, w_Data_Nxt;
`endif

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .i_Req   (bus.i_Req_DV),
    .i_Last  (r_Last),
    .o_Valid (w_Pick_Valid),
    .o_Idx   (w_Pick_Idx)
  );

  assign w_Pick_Byte = bus.i_Req_Byte[8*w_Pick_Idx +: 8];

  always_comb begin
    w_Next      = r_State;
    w_Last_Nxt  = r_Last;
    w_Grant_Nxt = r_Grant;
    w_Byte_Nxt  = r_Tx_Byte;
    w_Ack_Nxt   = '0;
`ifdef UART_ARB_TAG_EN
    w_Tag_Nxt   = r_Tag;
    w_Pend_Nxt  = r_Pend;
    w_Data_Nxt  = r_Data;
`endif
    case (r_State)
      ARB_IDLE: begin
        // A serializer still finishing a pre-reset frame blocks new grants.
        if (w_Pick_Valid && !bus.i_Tx_Active) begin
          w_Grant_Nxt = w_Pick_Idx;
          w_Next      = ARB_SEND;
`ifdef UART_ARB_TAG_EN
          w_Data_Nxt  = w_Pick_Byte;
          w_Tag_Nxt   = 1'b1;
          w_Pend_Nxt  = 1'b1;
          w_Byte_Nxt  = TAG_BASE | 8'(w_Pick_Idx);
`else
          w_Byte_Nxt  = w_Pick_Byte;
`endif
        end
      end
      ARB_SEND: w_Next = ARB_WAIT;
      ARB_WAIT: begin
        if (bus.i_Tx_Done) begin
          w_Next = ARB_SETTLE;
`ifdef UART_ARB_TAG_EN
          if (r_Tag) begin
            w_Tag_Nxt = 1'b0;
          end else begin
            w_Ack_Nxt[r_Grant] = 1'b1;
            w_Last_Nxt         = r_Grant;
          end
`else
          w_Ack_Nxt[r_Grant] = 1'b1;
          w_Last_Nxt         = r_Grant;
`endif
        end
      end
      ARB_SETTLE: begin
        if (!bus.i_Tx_Active) begin
          w_Next = ARB_IDLE;
`ifdef UART_ARB_TAG_EN
          if (r_Pend) begin
            w_Next     = ARB_SEND;
            w_Pend_Nxt = 1'b0;
            w_Byte_Nxt = r_Data;
          end
`endif
        end
      end
      default: w_Next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State   <= ARB_IDLE;
      r_Last    <= LAST_RST;
      r_Grant   <= '0;
      r_Tx_DV   <= 1'b0;
      r_Tx_Byte <= 8'h00;
      r_Ack     <= '0;
      r_Busy    <= 1'b0;
`ifdef UART_ARB_TAG_EN
      r_Tag     <= 1'b0;
      r_Pend    <= 1'b0;
      r_Data    <= 8'h00;
`endif
    end else begin
      r_State   <= w_Next;
      r_Last    <= w_Last_Nxt;
      r_Grant   <= w_Grant_Nxt;
      r_Tx_DV   <= (w_Next == ARB_SEND);
      r_Tx_Byte <= w_Byte_Nxt;
      r_Ack     <= w_Ack_Nxt;
      r_Busy    <= (w_Next != ARB_IDLE);
`ifdef UART_ARB_TAG_EN
      r_Tag     <= w_Tag_Nxt;
      r_Pend    <= w_Pend_Nxt;
      r_Data    <= w_Data_Nxt;
`endif
    end
  end

  assign bus.o_Tx_DV     = r_Tx_DV;
  assign bus.o_Tx_Byte   = r_Tx_Byte;
  assign bus.o_Req_Ack   = r_Ack;
  assign bus.o_Grant_Idx = r_Grant;
  assign bus.o_Busy      = r_Busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx frame model (no reset).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int FRAME  = 87 * 10;
  localparam int BUDGET = 4000;

  typedef struct {
    logic [1:0] idx;
    logic [3:0] ack;
  } ack_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #50 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_tx[$];
  ack_t       exp_ack[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Serializer model: accepts DV when idle, Active for FRAME cycles, Done with Active fall.
  logic       m_active = 1'b0;
  logic       m_done   = 1'b0;
  logic       f_active = 1'b0;
  logic [7:0] m_cap    = 8'h00;
  int         m_cnt    = 0;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (m_active) begin
      if (m_cnt == FRAME - 1) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (bus.o_Tx_DV) begin
      m_active <= 1'b1;
      m_cnt    <= 0;
      m_cap    <= bus.o_Tx_Byte;
    end
  end

  assign bus.i_Tx_Active = m_active | f_active;
  assign bus.i_Tx_Done   = m_done;

  // Monitor: pops expectations whenever the DUT presents DV, Done or Ack.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (bus.o_Tx_DV) begin
      chk("dv_while_active", 32'(bus.i_Tx_Active), 32'd0);
      if (exp_tx.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tx_unexpected: got byte %0h expected no frame", bus.o_Tx_Byte);
      end else begin
        chk("tx_byte", 32'(bus.o_Tx_Byte), 32'(exp_tx.pop_front()));
      end
    end
    // A Done while not busy is a leftover frame from before a reset.
    if (bus.i_Tx_Done && bus.o_Busy)
      chk("tx_stable", 32'(bus.o_Tx_Byte), 32'(m_cap));
    if (bus.o_Req_Ack != 4'b0000) begin
      chk("ack_after_done", 32'(prev_done), 32'd1);
      if (exp_ack.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ack_unexpected: got ack %0b expected none", bus.o_Req_Ack);
      end else begin
        ack_t e;
        e = exp_ack.pop_front();
        chk("ack_vec", 32'(bus.o_Req_Ack), 32'(e.ack));
        chk("grant_idx", 32'(bus.o_Grant_Idx), 32'(e.idx));
      end
    end
    prev_done = bus.i_Tx_Done;
  end

  task automatic push_tag(input int k);
`ifdef UART_ARB_TAG_EN
    exp_tx.push_back(ARB_TAG_BASE | 8'(k));
`endif
  endtask

  task automatic exp_grant(input int k, input logic [7:0] b);
    ack_t e;
    push_tag(k);
    exp_tx.push_back(b);
    e.idx = 2'(k);
    e.ack = 4'(1 << k);
    exp_ack.push_back(e);
  endtask

  task automatic set_req(input int k, input logic [7:0] b);
    bus.i_Req_Byte[8*k +: 8] = b;
    bus.i_Req_DV[k]          = 1'b1;
  endtask

  task automatic wait_ack(input int k, input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (bus.o_Req_Ack[k]) break;
    end
    chk($sformatf("ack%0d_seen", k), 32'(n < budget), 32'd1);
  endtask

  task automatic wait_dv(input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (bus.o_Tx_DV) break;
    end
    chk("dv_seen", 32'(n < budget), 32'd1);
  endtask

  task automatic ack_gone(input int k);
    @(negedge clk);
    chk($sformatf("ack%0d_one_cycle", k), 32'(bus.o_Req_Ack[k]), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dv"},    32'(bus.o_Tx_DV),     32'd0);
    chk({tag, "_byte"},  32'(bus.o_Tx_Byte),   32'h00);
    chk({tag, "_ack"},   32'(bus.o_Req_Ack),   32'd0);
    chk({tag, "_grant"}, 32'(bus.o_Grant_Idx), 32'd0);
    chk({tag, "_busy"},  32'(bus.o_Busy),      32'd0);
  endtask

  initial begin
    bus.i_Req_DV   = '0;
    bus.i_Req_Byte = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;

    // Single request from requester 2.
    exp_grant(2, 8'h5A);
    set_req(2, 8'h5A);
    wait_ack(2, BUDGET);
    bus.i_Req_DV[2] = 1'b0;
    ack_gone(2);
    repeat (4) @(negedge clk);
    chk("idle_busy", 32'(bus.o_Busy), 32'd0);

    // All four requesting from reset: order 0,1,2,3,0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) exp_grant(k, 8'h10 + 8'(k));
    exp_grant(0, 8'h10);
    for (int k = 0; k < 4; k++) set_req(k, 8'h10 + 8'(k));
    for (int n = 0; n < 5; n++) begin
      wait_ack(n % 4, BUDGET);
      if (n < 4) begin
        bus.i_Req_DV[n % 4] = 1'b0;
        ack_gone(n % 4);
        bus.i_Req_DV[n % 4] = 1'b1;
      end else begin
        bus.i_Req_DV = '0;
        ack_gone(0);
      end
    end
    repeat (10) @(negedge clk);

    // Requester 1 drops DV and scribbles its byte right after the grant.
    exp_grant(1, 8'h3C);
    set_req(1, 8'h3C);
    wait_dv(BUDGET);
    @(negedge clk);
    bus.i_Req_DV[1]       = 1'b0;
    bus.i_Req_Byte[15:8]  = 8'hFF;
    wait_ack(1, BUDGET);
    ack_gone(1);
    repeat (20) @(negedge clk);

    // Serializer held busy for 100 cycles with requester 0 pending.
    begin
      int dvs;
      dvs = 0;
      f_active = 1'b1;
      exp_grant(0, 8'h77);
      set_req(0, 8'h77);
      repeat (100) begin
        @(negedge clk);
        if (bus.o_Tx_DV) dvs++;
      end
      chk("busy_no_dv", 32'(dvs), 32'd0);
      f_active = 1'b0;
      @(negedge clk);
      chk("dv_after_release", 32'(bus.o_Tx_DV), 32'd1);
    end
    wait_ack(0, BUDGET);
    bus.i_Req_DV[0] = 1'b0;
    ack_gone(0);
    repeat (10) @(negedge clk);

    // Reset during WAIT; the next grant must wait for the serializer to finish.
`ifdef UART_ARB_TAG_EN
    exp_tx.push_back(ARB_TAG_BASE | 8'h02);
`else
    exp_tx.push_back(8'h21);
`endif
    set_req(2, 8'h21);
    wait_dv(BUDGET);
    repeat (50) @(negedge clk);
    chk("mid_frame_busy", 32'(bus.o_Busy), 32'd1);
    bus.i_Req_DV[2] = 1'b0;
    exp_grant(0, 8'h42);
    set_req(0, 8'h42);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_hold_dv", 32'(bus.o_Tx_DV), 32'd0);
    wait_ack(0, 2 * BUDGET);
    bus.i_Req_DV[0] = 1'b0;
    ack_gone(0);

    repeat (20) @(negedge clk);
    chk("tx_queue_empty",  32'(exp_tx.size()),  32'd0);
    chk("ack_queue_empty", 32'(exp_ack.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` serializer between `NUM_REQ` byte producers. Each producer holds a byte and a valid level. The arbiter grants one producer and latches its byte. It drives the serializer's `i_Tx_DV`/`i_Tx_Byte` handshake, waits for `o_Tx_Done`, and acknowledges the producer. It sits between on-chip producers and the `uart_tx` instance; the UART is not modified.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TAG_BASE`, 8'hA0: tag byte base (low 3 bits must be 0); used only with the tag feature.
- `i_Clock`  in  1  system clock, all logic on rising edge.
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_Req_DV`  in  NUM_REQ  per-requester valid level; held until that requester's `o_Req_Ack`.
- `i_Req_Byte`  in  8*NUM_REQ  requester k byte at [8k+7:8k].
- `o_Req_Ack`  out  NUM_REQ  one-hot, one-cycle pulse when that requester's data byte has finished transmitting.
- `o_Grant_Idx`  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- `o_Busy`  out  1  high whenever state != IDLE.
- `o_Tx_DV`  out  1  to `uart_tx.i_Tx_DV`.
- `o_Tx_Byte`  out  8  to `uart_tx.i_Tx_Byte`; stable from DV until the matching done.
- `i_Tx_Active`  in  1  from `uart_tx.o_Tx_Active`.
- `i_Tx_Done`  in  1  from `uart_tx.o_Tx_Done` (one-cycle pulse per frame).

## Operation
- States: IDLE, SEND, WAIT, SETTLE.
- **IDLE**
  - If any `i_Req_DV` bit is high and `i_Tx_Active` is low, select a winner by searching from `last+1` upward, wrapping modulo NUM_REQ.
  - Latch the winner's index into `o_Grant_Idx` and its byte into an internal data register.
  - Set `tag_phase` (tag feature only), then go to SEND.
  - If `i_Tx_Active` is high, wait; grant nothing.
- **SEND**
  - `o_Tx_DV` = 1 for exactly this one cycle.
  - `o_Tx_Byte` = tag byte if `tag_phase`, else the data register.
  - Go to WAIT.
- **WAIT**
  - Hold `o_Tx_Byte`.
  - On `i_Tx_Done` with `tag_phase`: clear `tag_phase` and go to SETTLE.
  - On `i_Tx_Done` without `tag_phase`: pulse `o_Req_Ack[o_Grant_Idx]`, set `last` = `o_Grant_Idx`, and go to SETTLE.
- **SETTLE**
  - Stay a minimum of 1 cycle, until `i_Tx_Active` is low.
  - Then go to SEND if the data byte is still pending (after a tag), else to IDLE.
  - This guarantees the requester has dropped or refreshed `i_Req_DV` before IDLE re-samples it.
- Requester deasserting `i_Req_DV` after grant: the latched byte is still sent and Ack is still pulsed. The arbiter never aborts a frame.
- Requester changing `i_Req_Byte` after grant: ignored; only the latched byte is sent.
- Reset value of `last` is NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-frame:
  - The arbiter returns to IDLE immediately.
  - `uart_tx` has no reset and may finish its frame.
  - The `i_Tx_Active` check in IDLE prevents issuing DV into a busy serializer.
  - A stray `i_Tx_Done` seen in IDLE is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - `o_Tx_DV`=0, `o_Tx_Byte`=8'h00, `o_Req_Ack`=0, `o_Grant_Idx`=0, `o_Busy`=0.
  - `last`=NUM_REQ-1, `tag_phase`=0.
- Grant latency: request sampled in IDLE at edge k (with `i_Tx_Active` low) → `o_Tx_DV` high in the cycle after edge k.
- Ack latency: `i_Tx_Done` sampled at edge m → `o_Req_Ack` high in the cycle after edge m, for 1 cycle.
- Minimum spacing between `o_Tx_DV` pulses: one UART frame + 2 cycles.
- Simultaneous requests are resolved only in IDLE. Requests arriving during a transfer wait; there is no preemption.

## Configuration
- Macro: `UART_ARB_TAG_EN`.
- Defined: each grant sends two frames, tag byte `TAG_BASE | o_Grant_Idx`, then the data byte. `o_Req_Ack` pulses only after the data frame.
- Undefined: `tag_phase` logic is removed and one frame is sent per grant. `TAG_BASE` is unused.

## Structure
- Shared package `uart_arb_pkg`: state enum (`ARB_IDLE`, `ARB_SEND`, `ARB_WAIT`, `ARB_SETTLE`), `ARB_MAX_REQ = 8`, default `TAG_BASE`.
- One sub-module, `rr_pick`: combinational round-robin winner search (inputs: request vector, `last`; outputs: valid, index). It is reusable by other arbiters.
- The top level holds the FSM and registers, and instantiates `rr_pick`.

## Test plan
Bench setup: `NUM_REQ`=4, 10 MHz clock, `uart_tx` and `uart_rx` with `CLKS_PER_BIT`=87, looped back.

- **Single request:** req2 byte 8'h5A, tag off → one DV pulse with 5A; RX gets 5A; `o_Req_Ack`=4'b0100 for 1 cycle, one cycle after done; `o_Grant_Idx`=2.
- **All four requesting:** all four from reset with bytes 8'h10..8'h13, re-asserting after each ack → RX order 10,11,12,13,10; no DV while `i_Tx_Active`=1.
- **Tag on:** `UART_ARB_TAG_EN`, req3 byte 8'hC3 → RX sees A3 then C3; exactly one ack, after the second done.
- **Drop after grant:** req1 drops DV and changes its byte to 8'hFF one cycle after DV → original byte is still sent; ack still pulses; no second grant.
- **Busy serializer:** `i_Tx_Active` forced high for 100 cycles with req0 pending → `o_Tx_DV` stays 0; DV follows 1 cycle after Active falls.
- **Reset mid-frame:** reset asserted during WAIT → all outputs are at reset values within the same cycle; the next grant goes to req0 only after `uart_tx` finishes its frame.
